// File: rtl/lr_barrel_shifter_pkg.sv
// Shared defaults and direction encoding for the logical barrel shifter.
// The shift-amount width is always derived from the data width.
package lr_barrel_shifter_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SHW_DEF   = $clog2(WIDTH_DEF);

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage : lr_barrel_shifter_pkg

// File: rtl/barrel_stage.sv
// One stage of the log2 shifter network.
// When en is high, the stage shifts by the fixed distance DIST in direction lr; otherwise it passes d through.
module barrel_stage
    import lr_barrel_shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             lr,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        if (en) begin
            if (lr == DIR_LEFT) begin
                q = d << DIST;
            end else begin
                q = d >> DIST;
            end
        end
    end

endmodule : barrel_stage

// File: rtl/lr_barrel_shifter.sv
// Bidirectional logical barrel shifter: log2 stage network followed by a single output register.
// The output register only loads on in_valid, so x holds its value while the shifter is idle.
module lr_barrel_shifter
    import lr_barrel_shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   s,
    input  logic             lr,
    input  logic             in_valid,
    output logic [WIDTH-1:0] x,
    output logic             out_valid
);

    // stage_w[k] is the input to stage k; stage_w[SHW] is the fully shifted word.
    logic [WIDTH-1:0] stage_w [SHW+1];
    logic [WIDTH-1:0] y;

    logic [WIDTH-1:0] x_q, x_d;
    logic             out_valid_q, out_valid_d;

    assign stage_w[0] = a;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        barrel_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .d  (stage_w[k]),
            .en (s[k]),
            .lr (lr),
            .q  (stage_w[k+1])
        );
    end

    assign y = stage_w[SHW];

    // Gating on in_valid keeps unknown idle-cycle operands away from x.
    always_comb begin
        x_d         = x_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            x_d         = y;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign x         = x_q;
    assign out_valid = out_valid_q;

endmodule : lr_barrel_shifter

// File: tb/tb_lr_barrel_shifter.sv
// Directed self-checking bench for lr_barrel_shifter with hand-computed vectors.
// It also includes a sweep over every shift amount and direction.
module tb_lr_barrel_shifter;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [3:0]  s;
    logic        lr;
    logic        in_valid;
    logic [15:0] x;
    logic        out_valid;

    int n_checks = 0;
    int n_errors = 0;

    lr_barrel_shifter u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .s         (s),
        .lr        (lr),
        .in_valid  (in_valid),
        .x         (x),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one valid operation, then sample one step after the capturing edge.
    task automatic op(input logic [15:0] av, input logic [3:0] sv, input logic lv,
                      input logic [15:0] exp, input string tag);
        a        = av;
        s        = sv;
        lr       = lv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " x"}, {16'h0, x}, {16'h0, exp});
        check({tag, " vld"}, {31'h0, out_valid}, 32'h1);
    endtask

    logic [15:0] last_x;
    logic [15:0] ra;
    logic [15:0] rexp;
    logic [3:0]  rs;
    logic        rl;

    initial begin
        // Reset asserted with a live operand presented.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 16'hFFFF;
        s        = 4'd0;
        lr       = 1'b0;
        #1;
        check("rst x immediate", {16'h0, x}, 32'h0);
        check("rst vld immediate", {31'h0, out_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst x held", {16'h0, x}, 32'h0);
        check("rst vld held", {31'h0, out_valid}, 32'h0);

        rst_n = 1'b1;
        #2;
        check("release x before edge", {16'h0, x}, 32'h0);
        check("release vld before edge", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("first capture x", {16'h0, x}, 32'h0000FFFF);
        check("first capture vld", {31'h0, out_valid}, 32'h1);

        // Back-to-back right then left shift.
        op(16'h4000, 4'd3, 1'b0, 16'h0800, "right s3");
        op(16'h2000, 4'd2, 1'b1, 16'h8000, "left s2");

        // Extremes.
        op(16'h8001, 4'd0,  1'b0, 16'h8001, "s0 right");
        op(16'h8001, 4'd0,  1'b1, 16'h8001, "s0 left");
        op(16'h8001, 4'd15, 1'b0, 16'h0001, "s15 right");
        op(16'h8001, 4'd15, 1'b1, 16'h8000, "s15 left");
        op(16'h0000, 4'd7,  1'b1, 16'h0000, "zero left");
        op(16'h0000, 4'd9,  1'b0, 16'h0000, "zero right");
        op(16'hF0F0, 4'd4,  1'b1, 16'h0F00, "drop left");
        op(16'hF0F0, 4'd4,  1'b0, 16'h0F0F, "drop right");

        // Hold: idle cycles with garbage operands must not disturb x.
        op(16'h1234, 4'd1, 1'b1, 16'h2468, "hold seed");
        last_x = 16'h2468;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b0;
            a        = 16'($urandom());
            s        = 4'($urandom_range(0, 15));
            lr       = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("hold x", {16'h0, x}, {16'h0, last_x});
            check("hold vld", {31'h0, out_valid}, 32'h0);
        end
        in_valid = 1'b0;
        a        = 'x;
        s        = 'x;
        lr       = 1'bx;
        @(posedge clk);
        #1;
        check("idle unknown x", {16'h0, x}, {16'h0, last_x});

        // Sweep every shift amount in both directions against a reference model.
        for (int i = 0; i < 32; i++) begin
            ra   = 16'($urandom());
            rs   = i[3:0];
            rl   = i[4];
            rexp = rl ? (ra << rs) : (ra >> rs);
            op(ra, rs, rl, rexp, "sweep");
        end

        // Reset in the middle of streaming: result lost at once.
        op(16'h00F0, 4'd4, 1'b1, 16'h0F00, "pre reset");
        a        = 16'hAAAA;
        s        = 4'd1;
        lr       = 1'b0;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst x", {16'h0, x}, 32'h0);
        check("mid rst vld", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("mid rst x after edge", {16'h0, x}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post rst x", {16'h0, x}, 32'h00005555);
        check("post rst vld", {31'h0, out_valid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_lr_barrel_shifter
